// File: rtl/jh_pkg.sv
// Shared constants for the bird renderer: screen geometry, colours, FSM states and the sprite mask.
// The sprite mask is only consumed when BIRD_SPRITE_EN is defined.
package jh_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    localparam logic [2:0] COL_BIRD = 3'b110;
    localparam logic [2:0] COL_BG   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Row dy is BIRD_SPRITE[dy]; within a row the leftmost bit is dx=0.
    localparam logic [0:15][0:15] BIRD_SPRITE = {
        16'b0110_0000_0000_0000,
        16'b1111_0000_0000_0000,
        16'b1101_0000_0000_0000,
        16'b0110_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000,
        16'b0000_0000_0000_0000
    };

endpackage

// File: rtl/bird_renderer_box_scanner.sv
// Row-major dx/dy walker over a BOX_W x BOX_H box; wraps to (0,0) after the last pixel.
module box_scanner #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       advance,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);

    localparam logic [3:0] DX_MAX = 4'(BOX_W - 1);
    localparam logic [3:0] DY_MAX = 4'(BOX_H - 1);

    logic [3:0] dx_reg;
    logic [3:0] dy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (restart) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (advance) begin
            if (dx_reg == DX_MAX) begin
                dx_reg <= '0;
                dy_reg <= (dy_reg == DY_MAX) ? 4'd0 : dy_reg + 4'd1;
            end else begin
                dx_reg <= dx_reg + 4'd1;
            end
        end
    end

    assign dx   = dx_reg;
    assign dy   = dy_reg;
    assign last = (dx_reg == DX_MAX) && (dy_reg == DY_MAX);

endmodule

// File: rtl/bird_renderer.sv
// Erase-then-draw plot engine for the bird box feeding a 160x120 vga_adapter.
// Define BIRD_SPRITE_EN to draw the jh_pkg::BIRD_SPRITE mask instead of a solid box.
module bird_renderer
    import jh_pkg::*;
#(
    parameter int         X_POS       = 20,
    parameter int         BOX_W       = 4,
    parameter int         BOX_H       = 4,
    parameter int         INIT_Y      = 56,
    parameter logic [2:0] BIRD_COLOUR = COL_BIRD,
    parameter logic [2:0] BG_COLOUR   = COL_BG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] new_y,
    output logic       busy,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       finished_draw
);

    localparam logic [6:0] Y_MAX = 7'(SCR_H - BOX_H);

    state_t     state_reg;
    logic [6:0] old_y_reg;
    logic [6:0] tgt_y_reg;
    logic       first_reg;
    logic       last_shown_reg;

    logic [3:0] dx;
    logic [3:0] dy;
    logic       scan_last;
    logic       scan_restart;
    logic       emit;
    logic       emit_draw;
    logic [6:0] emit_row;
    logic [6:0] clamped_y;
    logic [2:0] draw_colour;

    box_scanner #(.BOX_W(BOX_W), .BOX_H(BOX_H)) u_scanner (
        .clk     (clk),
        .rst     (reset),
        .restart (scan_restart),
        .advance (emit),
        .dx      (dx),
        .dy      (dy),
        .last    (scan_last)
    );

    assign clamped_y = (new_y > Y_MAX) ? Y_MAX : new_y;

`ifdef BIRD_SPRITE_EN
    assign draw_colour = BIRD_SPRITE[dy][dx] ? BIRD_COLOUR : BG_COLOUR;
`else
    assign draw_colour = BIRD_COLOUR;
`endif

    // The pixel shown in the next cycle is chosen here; last_shown_reg marks the phase boundary.
    always_comb begin
        emit         = 1'b0;
        emit_draw    = 1'b0;
        emit_row     = old_y_reg;
        scan_restart = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                emit         = start;
                emit_draw    = first_reg;
                emit_row     = first_reg ? clamped_y : old_y_reg;
                scan_restart = !start;
            end
            ST_ERASE: begin
                emit      = 1'b1;
                emit_draw = last_shown_reg;
                emit_row  = last_shown_reg ? tgt_y_reg : old_y_reg;
            end
            ST_DRAW: begin
                emit      = !last_shown_reg;
                emit_draw = 1'b1;
                emit_row  = tgt_y_reg;
            end
            default: scan_restart = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            old_y_reg      <= 7'(INIT_Y);
            tgt_y_reg      <= '0;
            first_reg      <= 1'b1;
            last_shown_reg <= 1'b0;
            busy           <= 1'b0;
            plot           <= 1'b0;
            finished_draw  <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            colour_out     <= '0;
        end else begin
            plot          <= emit;
            finished_draw <= 1'b0;
            if (emit) begin
                x_out          <= 8'(X_POS) + {4'd0, dx};
                y_out          <= emit_row + {3'd0, dy};
                colour_out     <= emit_draw ? draw_colour : BG_COLOUR;
                last_shown_reg <= scan_last;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        tgt_y_reg <= clamped_y;
                        busy      <= 1'b1;
                        state_reg <= first_reg ? ST_DRAW : ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    if (last_shown_reg) state_reg <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (last_shown_reg) begin
                        state_reg     <= ST_DONE;
                        old_y_reg     <= tgt_y_reg;
                        first_reg     <= 1'b0;
                        finished_draw <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bird_renderer.sv
// Randomised bench for bird_renderer against a pixel-list reference model of each erase+draw update.
module tb_bird_renderer;
    import jh_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XP = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] new_y;
    logic       busy;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       finished_draw;

    bird_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .new_y         (new_y),
        .busy          (busy),
        .x_out         (x_out),
        .y_out         (y_out),
        .colour_out    (colour_out),
        .plot          (plot),
        .finished_draw (finished_draw)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    int   checks = 0;
    int   errors = 0;
    int   model_old_y = 56;
    bit   model_first = 1'b1;
    pix_t exp_q[$];

    function automatic int bird_col(int dx, int dy);
`ifdef BIRD_SPRITE_EN
        logic [0:15][0:15] mask;
        mask = BIRD_SPRITE;
        return mask[dy][dx] ? 6 : 0;
`else
        return 6;
`endif
    endfunction

    // Whole expected screen-write sequence for one accepted start.
    task automatic build_expected(input int req_y);
        int tgt;
        tgt = (req_y > 120 - H) ? 120 - H : req_y;
        exp_q.delete();
        if (!model_first)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    exp_q.push_back('{x: XP + c, y: model_old_y + r, c: 0});
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back('{x: XP + c, y: tgt + r, c: bird_col(c, r)});
        model_old_y = tgt;
        model_first = 1'b0;
    endtask

    task automatic run_update(input int req_y, input bit spam, input string tag);
        int bad;
        int n;
        bad = 0;
        build_expected(req_y);
        n = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        new_y = 7'(req_y);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = spam;
            new_y = 7'($urandom_range(0, 127));
            checks++;
            if (plot !== 1'b1 || busy !== 1'b1 || finished_draw !== 1'b0 ||
                x_out !== 8'(exp_q[i].x) || y_out !== 7'(exp_q[i].y) ||
                colour_out !== 3'(exp_q[i].c)) begin
                errors++;
                bad++;
                $display("FAIL %s pixel %0d: got plot=%b busy=%b fd=%b (%0d,%0d) c=%b, need plot=1 busy=1 fd=0 (%0d,%0d) c=%0d",
                         tag, i, plot, busy, finished_draw, x_out, y_out, colour_out,
                         exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
            checks++;
            if (y_out > 7'd119) begin
                errors++;
                bad++;
                $display("FAIL %s y_bound: got y_out=%0d, need <=119", tag, y_out);
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (plot !== 1'b0 || finished_draw !== 1'b1 || busy !== 1'b1) begin
            errors++;
            bad++;
            $display("FAIL %s done_cycle: got plot=%b fd=%b busy=%b, need plot=0 fd=1 busy=1",
                     tag, plot, finished_draw, busy);
        end
        @(negedge clk);
        checks++;
        if (plot !== 1'b0 || finished_draw !== 1'b0 || busy !== 1'b0) begin
            errors++;
            bad++;
            $display("FAIL %s after_done: got plot=%b fd=%b busy=%b, need 0 0 0",
                     tag, plot, finished_draw, busy);
        end
        $display("update %s new_y=%0d pixels=%0d spam=%0d bad=%0d", tag, req_y, n, spam, bad);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        new_y = 7'd0;
        #1;
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0 || finished_draw !== 1'b0 ||
            x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b plot=%b fd=%b x=%0d y=%0d c=%b, need all zero",
                     busy, plot, finished_draw, x_out, y_out, colour_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_first = 1'b1;
        model_old_y = 56;
        $display("reset released");
    endtask

    task automatic test_idle_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            new_y = 7'($urandom_range(0, 127));
            checks++;
            if (plot !== 1'b0 || finished_draw !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: got plot=%b fd=%b busy=%b, need 0 0 0",
                         plot, finished_draw, busy);
            end
        end
        $display("idle quiet for %0d cycles", cycles);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        new_y = 7'd70;
        @(negedge clk);
        start = 1'b0;
        repeat (W * H + 5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || finished_draw !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got plot=%b busy=%b fd=%b, need 0 0 0",
                     plot, busy, finished_draw);
        end
        @(negedge clk);
        reset = 1'b0;
        model_first = 1'b1;
        $display("reset asserted mid-draw");
        run_update(10, 1'b0, "after_reset");
    endtask

    task automatic test_random(input int count);
        int y;
        for (int k = 0; k < count; k++) begin
            y = (k == 0) ? model_old_y : $urandom_range(0, 127);
            run_update(y, $urandom_range(0, 1) == 1, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_idle_quiet(3);
        run_update(30, 1'b0, "first_draw");
        run_update(40, 1'b0, "move");
        run_update(127, 1'b0, "clamp");
        run_update(60, 1'b1, "back_to_back");
        test_idle_quiet(4);
        test_reset_mid();
        test_random(8);
        test_idle_quiet(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
